// File: rtl/dds_sweep_controller_pkg.sv
// Shared DDS definitions: phase ROM geometry, derived tuning-word width and
// sweep controller state encoding.
package dds_sweep_controller_pkg;

  localparam int ROM_PHASE_BIT     = 12;
  localparam int ROM_PHASE_MAX_VAL = (1 << ROM_PHASE_BIT) - 1;
  localparam int SWEEP_M_W         = ROM_PHASE_BIT - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dds_sweep_controller_dwell_counter.sv
// Dwell counter: synchronous load / decrement with zero flag, resets to 0.
module dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  // load has priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_controller.sv
// DDS tuning-word sweep sequencer (start/stop/step/dwell, single or
// continuous, constant-tone hold, abort).
// Optional: define DDS_SWEEP_TRIANGLE_EN to add cfg_tri (up/down sweep).
module dds_sweep_controller
  import dds_sweep_controller_pkg::*;
#(
  parameter int M_W     = SWEEP_M_W,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [M_W-1:0]     cfg_start,
  input  logic [M_W-1:0]     cfg_stop,
  input  logic [M_W-1:0]     cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_cont,
`ifdef DDS_SWEEP_TRIANGLE_EN
  input  logic               cfg_tri,
`endif
  input  logic               abort,
  output logic [M_W-1:0]     M,
  output logic               acc_rst,
  output logic               busy,
  output logic               done
);

  typedef struct packed {
    logic [M_W-1:0]     start;
    logic [M_W-1:0]     stop;
    logic [M_W-1:0]     step;
    logic [DWELL_W-1:0] dwell;
    logic               cont;
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic               tri_mode;
`endif
  } cfg_t;

  sweep_state_e       state_q, state_d;
  cfg_t               cfg_q, cfg_in;
  logic               accept, run_sweep;
  logic               cnt_zero, cnt_load, cnt_dec;
  logic [DWELL_W-1:0] cnt_val;
  logic [M_W:0]       nxt_up;
  logic               ok_up, fin;
  logic [M_W-1:0]     m_d;
  logic               acc_rst_d, done_d;

  assign accept    = cfg_valid && (state_q == ST_IDLE);
  // a sweep needs a non-zero step and a non-empty range; otherwise hold a tone
  assign run_sweep = (cfg_step != '0) && (cfg_start <= cfg_stop);

  always_comb begin
    cfg_in       = '0;
    cfg_in.start = cfg_start;
    cfg_in.stop  = cfg_stop;
    cfg_in.step  = cfg_step;
    cfg_in.dwell = cfg_dwell;
    cfg_in.cont  = cfg_cont;
`ifdef DDS_SWEEP_TRIANGLE_EN
    cfg_in.tri_mode = cfg_tri;
`endif
  end

  // carry kept in bit M_W so an overflowing step ends the sweep, never wraps
  assign nxt_up = {1'b0, M} + {1'b0, cfg_q.step};
  assign ok_up  = !nxt_up[M_W] && (nxt_up[M_W-1:0] <= cfg_q.stop);

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic         dir_dn_q, dir_dn_d;
  logic [M_W:0] nxt_dn;
  logic         ok_dn;
  assign nxt_dn = {1'b0, M} - {1'b0, cfg_q.step};
  assign ok_dn  = !nxt_dn[M_W] && (nxt_dn[M_W-1:0] >= cfg_q.start);
  // single triangle finishes at the bottom (or at a top it cannot descend from)
  assign fin = !cfg_q.cont &&
               ((cfg_q.tri_mode && dir_dn_q) ? !ok_dn
                                             : (!ok_up && !(cfg_q.tri_mode && ok_dn)));
`else
  assign fin = !cfg_q.cont && !ok_up;
`endif

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // state register and config latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cfg_q <= cfg_in;
    end
  end

  // next-state: abort beats dwell/step, single sweep end returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_valid) state_d = run_sweep ? ST_RUN : ST_HOLD;
      ST_RUN:  if (abort || (cnt_zero && fin)) state_d = ST_IDLE;
      ST_HOLD: if (abort) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // output/datapath next values
  always_comb begin
    m_d       = M;
    acc_rst_d = 1'b0;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = cfg_q.dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
    dir_dn_d  = dir_dn_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          m_d       = cfg_start;
          acc_rst_d = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = cfg_dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
          dir_dn_d  = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (abort) begin
          m_d = '0;
`ifdef DDS_SWEEP_TRIANGLE_EN
          dir_dn_d = 1'b0;
`endif
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          cnt_load = 1'b1;
          done_d   = fin;
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (cfg_q.tri_mode && dir_dn_q) begin
            if (ok_dn) m_d = nxt_dn[M_W-1:0];
            else if (cfg_q.cont) begin
              dir_dn_d = 1'b0;
              if (ok_up) m_d = nxt_up[M_W-1:0];
            end
          end else if (ok_up) begin
            m_d = nxt_up[M_W-1:0];
          end else if (cfg_q.tri_mode && ok_dn) begin
            m_d      = nxt_dn[M_W-1:0];
            dir_dn_d = 1'b1;
          end else if (cfg_q.cont) begin
            m_d = cfg_q.start;
          end
`else
          if (ok_up)           m_d = nxt_up[M_W-1:0];
          else if (cfg_q.cont) m_d = cfg_q.start;
`endif
        end
      end
      ST_HOLD: begin
        if (abort) m_d = '0;
`ifdef DDS_SWEEP_TRIANGLE_EN
        if (abort) dir_dn_d = 1'b0;
`endif
      end
      default: m_d = '0;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      M         <= '0;
      acc_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      M         <= m_d;
      acc_rst   <= acc_rst_d;
      busy      <= (state_d != ST_IDLE);
      done      <= done_d;
      cfg_ready <= (state_d == ST_IDLE);
    end
  end

`ifdef DDS_SWEEP_TRIANGLE_EN
  // sweep direction, up after reset
  always_ff @(posedge clk) begin
    if (rst) dir_dn_q <= 1'b0;
    else     dir_dn_q <= dir_dn_d;
  end
`endif

endmodule
